// File: rtl/io_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_tx_pkg
// Purpose  : Shared definitions for the TX unpacker: FSM state encoding,
//            datasize encodings and a helper that maps an encoding to the
//            number of bytes taken from each upstream word.
// Revision : 1.0 - initial release
// ============================================================================
package io_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

  // Encoding 3 is reserved and behaves like a full 4-byte word.
  function automatic logic [2:0] dsize_bytes(input logic [1:0] dsize);
    logic [2:0] n;
    case (dsize)
      DSIZE_BYTE: n = 3'd1;
      DSIZE_HALF: n = 3'd2;
      default:    n = 3'd4;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_tx_unpack.sv
`default_nettype none
// ============================================================================
// Module   : io_tx_unpack
// Purpose  : Splits words from an upstream TX FIFO into a little-endian byte
//            stream for a peripheral, 1, 2 or 4 bytes per word, for a
//            transfer of cfg_size_i bytes.
// Ports    : clk_i, rstn_i (async active-low), clr_i (sync abort)
//            cfg_en_i / cfg_datasize_i / cfg_size_i : transfer setup (IDLE only)
//            data_i / valid_i / ready_o             : upstream word handshake
//            data_o / valid_o / ready_i / last_o    : downstream byte handshake
//            busy_o (RUN), done_o (1-cycle completion pulse)
// Revision : 1.0 - initial release
// ============================================================================
module io_tx_unpack
  import io_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 20
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  cfg_en_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic [SIZE_WIDTH-1:0] cfg_size_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // Bytes physically present in one input word, capped at the 4-byte maximum.
  localparam int         C_BPW     = DATA_WIDTH / 8;
  localparam logic [2:0] C_BPW_CAP = (C_BPW >= 4) ? 3'd4 : 3'(C_BPW);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [1:0]            r_idx;
  logic [2:0]            r_nbytes;
  logic                  r_held;
  logic [SIZE_WIDTH-1:0] r_remaining;
  logic [1:0]            r_dsize;

  logic                  w_run;
  logic                  w_valid;
  logic                  w_byte_acc;
  logic                  w_word_end;
  logic                  w_xfer_end;
  logic                  w_ready;
  logic                  w_word_acc;
  logic [SIZE_WIDTH-1:0] w_rem_dec;
  logic [SIZE_WIDTH-1:0] w_rem_after;
  logic [2:0]            w_nbytes_new;

  assign w_run      = (r_state == ST_RUN);
  assign w_valid    = w_run & r_held;
  assign w_byte_acc = w_valid & ready_i;
  assign w_word_end = ({1'b0, r_idx} == (r_nbytes - 3'd1));
  assign w_xfer_end = (r_remaining == SIZE_WIDTH'(1));

  // A new word may enter when nothing is held, or in the same cycle the held
  // word's final byte leaves (back-to-back). Never while the transfer's final
  // byte is leaving: no more words belong to this transfer.
  assign w_ready    = w_run & ~(w_byte_acc & w_xfer_end)
                    & (~r_held | (w_byte_acc & w_word_end));
  assign w_word_acc = valid_i & w_ready;

  // Saturating decrement; r_remaining must never wrap.
  assign w_rem_dec   = r_remaining - SIZE_WIDTH'(r_remaining != '0);
  assign w_rem_after = w_byte_acc ? w_rem_dec : r_remaining;

  // Bytes to emit from a newly accepted word. Uses the count after any byte
  // accepted in the same cycle so a back-to-back final word is trimmed
  // correctly (its surplus upper bytes are never presented).
  always_comb begin
    w_nbytes_new = dsize_bytes(r_dsize);
    if (w_nbytes_new > C_BPW_CAP) begin
      w_nbytes_new = C_BPW_CAP;
    end
    if (SIZE_WIDTH'(w_nbytes_new) > w_rem_after) begin
      w_nbytes_new = w_rem_after[2:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_en_i) begin
          w_state_nxt = (cfg_size_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_byte_acc & w_xfer_end) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clr_i) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_word      <= '0;
      r_idx       <= '0;
      r_nbytes    <= '0;
      r_held      <= 1'b0;
      r_remaining <= '0;
      r_dsize     <= '0;
    end else if (clr_i) begin
      r_held      <= 1'b0;
      r_idx       <= '0;
      r_remaining <= '0;
    end else begin
      if ((r_state == ST_IDLE) && cfg_en_i) begin
        r_remaining <= cfg_size_i;
        r_dsize     <= cfg_datasize_i;
      end
      if (w_byte_acc) begin
        r_remaining <= w_rem_dec;
        r_idx       <= r_idx + 2'd1;
        if (w_word_end | w_xfer_end) begin
          r_held <= 1'b0;
        end
      end
      // A word accepted together with the previous word's last byte overrides
      // the clear above.
      if (w_word_acc) begin
        r_word   <= data_i;
        r_idx    <= '0;
        r_nbytes <= w_nbytes_new;
        r_held   <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ready_o = w_ready;
  assign valid_o = w_valid;
  assign data_o  = r_word[8*r_idx +: 8];
  assign last_o  = w_valid & w_xfer_end;
  assign busy_o  = w_run;
  assign done_o  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_io_tx_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_tx_unpack
// Purpose  : Self-checking bench for io_tx_unpack. A queue-based model turns
//            each accepted word into the bytes the transfer must produce and
//            is checked against the DUT every cycle; directed transfers add
//            hand-computed byte lists and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_tx_unpack;

  localparam int DW = 32;
  localparam int SW = 20;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          clr_i;
  logic          cfg_en_i;
  logic [1:0]    cfg_datasize_i;
  logic [SW-1:0] cfg_size_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [7:0]    data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  io_tx_unpack #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .clr_i          (clr_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_datasize_i (cfg_datasize_i),
    .cfg_size_i     (cfg_size_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model + per-cycle compare (samples on the falling edge)
  // --------------------------------------------------------------------------
  typedef struct packed { logic [7:0] b; logic last; } exp_t;
  exp_t        exp_q[$];
  int          m_unassigned = 0;   // transfer bytes not yet covered by a word
  logic [1:0]  m_ds = '0;
  bit          m_active = 0;
  bit          m_done_due = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;
  int          cyc_n = 0;

  logic [7:0]  byte_log[$];
  logic        last_log[$];
  int          stamp_log[$];
  int          done_stamp = -1;
  int          start_stamp = -1;

  always @(negedge clk_i) begin
    bit   idle;
    exp_t e;
    int   n;
    cyc_n++;
    idle = !m_active && !m_done_due;
    if (!rstn_i || clr_i) begin
      // Anything handshaken on this edge is discarded by the abort.
      exp_q.delete();
      m_unassigned = 0;
      m_active     = 0;
      m_done_due   = 0;
      prev_stall   = 0;
    end else begin
      chk_eq("done", done_o, m_done_due);
      if (done_o) done_stamp = cyc_n;
      m_done_due = 0;
      chk_eq("busy", busy_o, m_active);
      chk_eq("valid", valid_o, exp_q.size() != 0);
      if (ready_o && !(m_active && m_unassigned > 0))
        chk_eq("ready_unexpected", ready_o, 1'b0);
      if (prev_stall) begin
        chk_eq("stall_valid", valid_o, 1'b1);
        chk_eq("stall_data", data_o, prev_data);
      end
      if (valid_o && ready_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_eq("byte", data_o, e.b);
        chk_eq("last", last_o, e.last);
        byte_log.push_back(data_o);
        last_log.push_back(last_o);
        stamp_log.push_back(cyc_n);
        if (e.last) begin
          m_active   = 0;
          m_done_due = 1;
        end
      end else if (valid_o) begin
        chk_eq("last_hold", last_o, exp_q.size() == 1 && exp_q[0].last);
      end
      if (valid_i && ready_o && m_active && m_unassigned > 0) begin
        n = (m_ds == 2'd0) ? 1 : (m_ds == 2'd1) ? 2 : 4;
        if (n > m_unassigned) n = m_unassigned;
        for (int k = 0; k < n; k++) begin
          e.b    = data_i[8*k +: 8];
          e.last = (k == n - 1) && (m_unassigned == n);
          exp_q.push_back(e);
        end
        m_unassigned -= n;
      end
      if (idle && cfg_en_i) begin
        start_stamp  = cyc_n;
        m_ds         = cfg_datasize_i;
        m_unassigned = int'(cfg_size_i);
        if (cfg_size_i == '0) m_done_due = 1;
        else m_active = 1;
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [DW-1:0] words [16];
  logic [7:0]    exp_lit[$];

  task automatic clear_logs();
    byte_log.delete();
    last_log.delete();
    stamp_log.delete();
    done_stamp  = -1;
    start_stamp = -1;
  endtask

  task automatic check_log(input string nm);
    int n;
    chk_eq({nm, "_count"}, byte_log.size(), exp_lit.size());
    n = (byte_log.size() < exp_lit.size()) ? byte_log.size() : exp_lit.size();
    for (int i = 0; i < n; i++) begin
      chk_eq($sformatf("%s_b%0d", nm, i), byte_log[i], exp_lit[i]);
      chk_eq($sformatf("%s_l%0d", nm, i), last_log[i], i == exp_lit.size() - 1);
    end
  endtask

  // Runs one transfer. abort_at >= 0 aborts (clr_i, or reset when abort_rst)
  // right after that many bytes have been accepted.
  task automatic run_xfer(input logic [1:0] ds, input int sz, input int nw,
                          input bit tog, input bit gap, input int abort_at,
                          input bit abort_rst, output bit saw_ready);
    int wi = 0, nb = 0, cyc = 0;
    bit acc, bacc, aborting = 0, gap_now;
    saw_ready = 0;
    @(posedge clk_i); #1;
    cfg_en_i       = 1'b1;
    cfg_datasize_i = ds;
    cfg_size_i     = SW'(sz);
    valid_i        = (nw > 0);
    data_i         = words[0];
    ready_i        = !tog;
    forever begin
      @(negedge clk_i);
      if (ready_o) saw_ready = 1;
      acc  = valid_i & ready_o;
      bacc = valid_o & ready_i;
      if (bacc) nb++;
      if (aborting && abort_rst) begin
        chk_eq("rst_mid_valid", valid_o, 1'b0);
        chk_eq("rst_mid_busy", busy_o, 1'b0);
        chk_eq("rst_mid_data", data_o, 8'h00);
      end
      if (done_o && !aborting) break;
      cyc++;
      if (cyc > 300) begin
        chk_eq("timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk_i); #1;
      if (aborting) begin
        clr_i  = 1'b0;
        rstn_i = 1'b1;
        break;
      end
      cfg_en_i       = 1'b0;
      cfg_size_i     = SW'($urandom);     // must be ignored outside IDLE
      cfg_datasize_i = 2'($urandom);
      gap_now = 0;
      if (acc) begin
        wi++;
        gap_now = gap && (wi % 2 == 1);
      end
      valid_i = (wi < nw) && !gap_now;
      data_i  = (wi < nw && wi < 16) ? words[wi] : 32'hDEAD_BEEF;
      ready_i = tog ? ~ready_i : 1'b1;
      if (abort_at >= 0 && nb == abort_at) begin
        aborting = 1;
        if (abort_rst) rstn_i = 1'b0;
        else clr_i = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    valid_i  = 1'b0;
    cfg_en_i = 1'b0;
  endtask

  initial begin
    bit sr;
    rstn_i = 1'b0; clr_i = 1'b0; cfg_en_i = 1'b0; cfg_datasize_i = '0;
    cfg_size_i = '0; data_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_eq("rst_ready", ready_o, 1'b0);
    chk_eq("rst_valid", valid_o, 1'b0);
    chk_eq("rst_last",  last_o,  1'b0);
    chk_eq("rst_busy",  busy_o,  1'b0);
    chk_eq("rst_done",  done_o,  1'b0);
    chk_eq("rst_data",  data_o,  8'h00);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // Full words, back-to-back, ready always high.
    words[0] = 32'h44332211; words[1] = 32'h88776655;
    clear_logs();
    run_xfer(2'd2, 8, 2, 0, 0, -1, 0, sr);
    exp_lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_log("w8");
    if (stamp_log.size() == 8) begin
      chk_eq("w8_first_lat", stamp_log[0] - start_stamp, 32'd2);
      chk_eq("w8_span", stamp_log[7] - stamp_log[0], 32'd7);
      chk_eq("w8_done_lat", done_stamp - stamp_log[7], 32'd1);
    end

    // One byte per word; upper bytes ignored.
    words[0] = 32'hDEADBEAA; words[1] = 32'h123456BB; words[2] = 32'hFFFFFFCC;
    clear_logs();
    run_xfer(2'd0, 3, 3, 0, 0, -1, 0, sr);
    exp_lit = '{8'hAA, 8'hBB, 8'hCC};
    check_log("b3");

    // Final partial word.
    words[0] = 32'h44332211; words[1] = 32'h88776655;
    clear_logs();
    run_xfer(2'd2, 6, 2, 0, 0, -1, 0, sr);
    exp_lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    check_log("p6");

    // Zero-length transfer.
    clear_logs();
    run_xfer(2'd2, 0, 1, 0, 0, -1, 0, sr);
    chk_eq("z0_ready_seen", sr, 1'b0);
    chk_eq("z0_done_lat", done_stamp - start_stamp, 32'd1);
    chk_eq("z0_bytes", byte_log.size(), 32'd0);

    // Backpressure and upstream gaps.
    words[0] = 32'hA3A2A1A0; words[1] = 32'hB3B2B1B0; words[2] = 32'hC3C2C1C0;
    clear_logs();
    run_xfer(2'd2, 11, 3, 1, 1, -1, 0, sr);
    exp_lit = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                8'hC0, 8'hC1, 8'hC2};
    check_log("g11");

    words[0] = 32'hFFFF1100; words[1] = 32'hFFFF3322;
    words[2] = 32'hFFFF5544; words[3] = 32'hFFFF7766;
    clear_logs();
    run_xfer(2'd1, 7, 4, 1, 0, -1, 0, sr);
    exp_lit = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    check_log("h7");

    // Reserved datasize behaves as 4 bytes.
    words[0] = 32'h04030201; words[1] = 32'h08070605;
    clear_logs();
    run_xfer(2'd3, 5, 2, 0, 0, -1, 0, sr);
    exp_lit = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_log("r5");

    // Abort with clr_i mid-word, then restart.
    for (int i = 0; i < 5; i++) words[i] = 32'h0000_0000 | ((i * 2 + 1) << 8) | (i * 2);
    clear_logs();
    run_xfer(2'd1, 10, 5, 0, 0, 3, 0, sr);
    @(negedge clk_i);
    chk_eq("clr_busy", busy_o, 1'b0);
    chk_eq("clr_valid", valid_o, 1'b0);
    chk_eq("clr_ready", ready_o, 1'b0);
    repeat (3) @(negedge clk_i);
    chk_eq("clr_no_done", done_stamp, 32'hFFFF_FFFF);
    words[0] = 32'h0000BBAA; words[1] = 32'h0000DDCC;
    clear_logs();
    run_xfer(2'd1, 4, 2, 0, 0, -1, 0, sr);
    exp_lit = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check_log("clr_restart");

    // Reset mid-transfer, then restart.
    words[0] = 32'h44332211; words[1] = 32'h88776655;
    clear_logs();
    run_xfer(2'd2, 8, 2, 0, 0, 2, 1, sr);
    @(negedge clk_i);
    chk_eq("rst_resume_busy", busy_o, 1'b0);
    chk_eq("rst_resume_valid", valid_o, 1'b0);
    clear_logs();
    run_xfer(2'd2, 8, 2, 0, 0, -1, 0, sr);
    exp_lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_log("rst_restart");

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_tx_unpack.md
IO_TX_UNPACK -- requirements
Module: io_tx_unpack

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, input word width, a multiple of 8.
REQ-002 The block SHALL have parameter SIZE_WIDTH, default 20, transfer byte-count width.
REQ-003 The block SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port rstn_i  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clr_i  input  1  synchronous abort/clear.
REQ-006 The block SHALL have port cfg_en_i  input  1  start request, sampled only in IDLE.
REQ-007 The block SHALL have port cfg_datasize_i  input  2  bytes used per word: 0=1, 1=2, 2=4, 3=reserved (treated as 4).
REQ-008 The block SHALL have port cfg_size_i  input  SIZE_WIDTH  transfer length in bytes.
REQ-009 The block SHALL have port data_i  input  DATA_WIDTH  word from the upstream TX FIFO.
REQ-010 The block SHALL have port valid_i  input  1  upstream word valid.
REQ-011 The block SHALL have port ready_o  output  1  word accepted when valid_i & ready_o.
REQ-012 The block SHALL have port data_o  output  8  byte to the peripheral.
REQ-013 The block SHALL have port valid_o  output  1  data_o valid.
REQ-014 The block SHALL have port ready_i  input  1  byte accepted when valid_o & ready_i.
REQ-015 The block SHALL have port last_o  output  1  high with the final byte of the transfer.
REQ-016 The block SHALL have port busy_o  output  1  high in RUN.
REQ-017 The block SHALL have port done_o  output  1  one-cycle pulse at normal transfer completion.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE.
REQ-019 IDLE with cfg_en_i=1: latch cfg_size_i into r_remaining and cfg_datasize_i into r_dsize, then go to RUN (or DONE if cfg_size_i=0); config changes outside IDLE are ignored.
REQ-020 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-021 RUN: ready_o = ~r_held | (valid_o & ready_i & r_byte_is_last_of_word), and the combinational path ready_i->ready_o is permitted.
REQ-022 On word accept: latch data_i, set r_idx=0, set r_nbytes=min(2^r_dsize, r_remaining), set r_held=1; byte 0 SHALL appear on data_o the next cycle (1-cycle latency).
REQ-023 Byte order SHALL be little-endian: data_o = word[8*r_idx+7 : 8*r_idx]; valid_o = r_held in RUN.
REQ-024 On byte accept: r_idx++ and r_remaining--; on the last byte of the word r_held is cleared unless a new word is accepted in the same cycle (back-to-back, no bubble).
REQ-025 last_o SHALL be valid_o & (r_remaining==1); when that byte is accepted the FSM goes to DONE and ready_o SHALL be 0 in that cycle.
REQ-026 Unused upper bytes of a final partial word SHALL be discarded.
REQ-027 ready_o and valid_o SHALL be 0 in IDLE and DONE.
REQ-028 r_remaining SHALL never wrap; decrement occurs only when it is nonzero.
REQ-029 clr_i SHALL take priority over all events: clear r_held, r_idx and r_remaining, go to IDLE, with no done_o pulse.

Reset
REQ-030 During reset: state=IDLE and all registers are 0; ready_o, valid_o, last_o, busy_o, done_o = 0 and data_o = 0.
REQ-031 Reset deassertion mid-transfer SHALL resume in IDLE with no residual word.

Structure
REQ-032 Shared package io_tx_pkg SHALL hold the FSM state enum and datasize encoding constants (DSIZE_BYTE/HALF/WORD).
REQ-033 The block SHALL be a single module with no sub-module; the byte mux is inline.

Verification
REQ-034 dsize=2, size=8, words 0x44332211, 0x88776655, ready_i=1 -> bytes 11..88 on consecutive cycles, last_o on 0x88, done_o one cycle later.
REQ-035 dsize=0, size=3, words 0xAA, 0xBB, 0xCC -> bytes AA, BB, CC; one word consumed per byte; upper bytes ignored.
REQ-036 dsize=2, size=6 -> second word yields only 2 bytes, last_o on byte 6, bytes 3-4 of that word dropped.
REQ-037 size=0 with cfg_en_i=1 -> done_o in the next cycle, ready_o never asserted.
REQ-038 ready_i toggling 1/0 with valid_i gaps -> no byte lost or duplicated; data_o stable while valid_o & ~ready_i.
REQ-039 clr_i asserted mid-word (dsize=1, size=10, after 3 bytes) -> IDLE next cycle, no done_o; a restarted transfer is correct.
